// File: rtl/src_pp_buf.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | src_pp_buf: ping-pong fp32->bf16 source buffer, host fill / exec read     |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
module src_pp_buf #(
  parameter int NBANK = 2,
  parameter int DEPTH = 512,
  parameter int DW    = 64,
  parameter int RND   = 0,
  localparam int LANES = DW / 32,
  localparam int AW    = $clog2(NBANK * DEPTH),
  localparam int IAW   = $clog2(NBANK * DEPTH * LANES)
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           src_v,
  input  logic [AW-1:0]  src_a,
  input  logic [DW-1:0]  src_d,
  input  logic           src_last,
  output logic           fill_rdy,
  input  logic           exec,
  input  logic [IAW-1:0] ia,
  output logic [15:0]    d,
  output logic           d_v,
  output logic           rd_rdy,
  input  logic           rd_done,
  output logic           ovf
);

  localparam int LGL = $clog2(LANES);
  localparam int LSW = (LGL > 0) ? LGL : 1;
  localparam int WW  = LANES * 16;

  function automatic logic [15:0] to_bf16(input logic [31:0] x);
    logic [15:0] r;
    r = x[31:16];
    if (RND != 0) begin
      // NaN payload is kept non-zero by forcing the quiet bit.
      if (x[30:23] == 8'hFF) begin
        if (x[22:0] != 23'd0) r[6] = 1'b1;
      end else begin
        r = x[31:16] + {15'd0, x[15] & ((x[14:0] != 15'd0) | x[16])};
      end
    end
    return r;
  endfunction

  logic [WW-1:0] mem [2*NBANK*DEPTH];

  logic [1:0]     state_q, state_d;
  logic           wsel_q, wsel_d;
  logic           rsel_q, rsel_d;
  logic           ovf_q, ovf_d;
  logic           d_v_q, d_v_d;
  logic [15:0]    d_q, d_d;

  logic [WW-1:0]  wr_word;
  logic [WW-1:0]  rd_word;
  logic [LSW-1:0] lane;
  logic           wr_en, close_set, release_set, rd_fire;

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    assign wr_word[16*k +: 16] = to_bf16(src_d[32*k +: 32]);
  end

  assign fill_rdy    = ~state_q[wsel_q];
  assign rd_rdy      = state_q[rsel_q];
  assign wr_en       = src_v & fill_rdy;
  assign close_set   = wr_en & src_last;
  assign release_set = rd_done & rd_rdy;
  assign rd_fire     = exec & rd_rdy;

  assign rd_word = mem[{rsel_q, ia[IAW-1:LGL]}];
  assign lane    = ia[LSW-1:0] & LSW'(LANES - 1);

  always_comb begin
    state_d = state_q;
    wsel_d  = wsel_q;
    rsel_d  = rsel_q;
    d_d     = d_q;
    d_v_d   = rd_fire;
    ovf_d   = ovf_q | (src_v & ~fill_rdy) | (exec & ~rd_rdy);
    // A set can't be both FREE (fill) and FULL (read), so these never collide.
    if (close_set) begin
      state_d[wsel_q] = 1'b1;
      wsel_d          = ~wsel_q;
    end
    if (release_set) begin
      state_d[rsel_q] = 1'b0;
      rsel_d          = ~rsel_q;
    end
    if (rd_fire) d_d = rd_word[16*lane +: 16];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= 2'b00;
      wsel_q  <= 1'b0;
      rsel_q  <= 1'b0;
      ovf_q   <= 1'b0;
      d_v_q   <= 1'b0;
      d_q     <= 16'd0;
    end else begin
      state_q <= state_d;
      wsel_q  <= wsel_d;
      rsel_q  <= rsel_d;
      ovf_q   <= ovf_d;
      d_v_q   <= d_v_d;
      d_q     <= d_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en && !reset) mem[{wsel_q, src_a}] <= wr_word;
  end

  assign d   = d_q;
  assign d_v = d_v_q;
  assign ovf = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_src_pp_buf.sv
`default_nettype none
// Directed bench for src_pp_buf: truncating and RNE instances share stimulus.
module tb_src_pp_buf;

  localparam int AW  = 10;
  localparam int IAW = 11;

  localparam logic [63:0] W0 = 64'h4049_0FDB_3F80_0000;
  localparam logic [63:0] W1 = 64'h3F81_8000_3F80_8000;
  localparam logic [63:0] W2 = 64'h7F80_0001_3F80_8001;
  localparam logic [63:0] W3 = 64'h4000_0000_C000_0000;
  localparam logic [63:0] W4 = 64'h3F00_0000_4080_0000;
  localparam logic [63:0] W5 = 64'h4100_0000_4120_0000;
  localparam logic [63:0] W6 = 64'h4140_0000_4160_0000;
  localparam logic [63:0] WF = 64'hFFFF_FFFF_FFFF_FFFF;

  typedef struct {
    logic           rst, v;
    logic [AW-1:0]  a;
    logic [63:0]    dat;
    logic           last, ex;
    logic [IAW-1:0] ia;
    logic           done;
    logic           e_dv;
    logic [15:0]    e_dt, e_dr;
    logic           e_fr, e_rr, e_ovf;
  } vec_t;

  logic           clk = 1'b0;
  logic           reset, src_v, src_last, exec, rd_done;
  logic [AW-1:0]  src_a;
  logic [63:0]    src_d;
  logic [IAW-1:0] ia;
  logic           fr_t, rr_t, dv_t, ovf_t, fr_r, rr_r, dv_r, ovf_r;
  logic [15:0]    d_t, d_r;

  int checks = 0;
  int failures = 0;
  vec_t vecs[$];

  always #5 clk = ~clk;

  src_pp_buf #(.NBANK(2), .DEPTH(512), .DW(64), .RND(0)) u_trn (
    .clk(clk), .reset(reset), .src_v(src_v), .src_a(src_a), .src_d(src_d),
    .src_last(src_last), .fill_rdy(fr_t), .exec(exec), .ia(ia), .d(d_t),
    .d_v(dv_t), .rd_rdy(rr_t), .rd_done(rd_done), .ovf(ovf_t));

  src_pp_buf #(.NBANK(2), .DEPTH(512), .DW(64), .RND(1)) u_rne (
    .clk(clk), .reset(reset), .src_v(src_v), .src_a(src_a), .src_d(src_d),
    .src_last(src_last), .fill_rdy(fr_r), .exec(exec), .ia(ia), .d(d_r),
    .d_v(dv_r), .rd_rdy(rr_r), .rd_done(rd_done), .ovf(ovf_r));

  task automatic chk(input string nm, input int idx, input logic [15:0] act,
                     input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s step=%0d got=%h want=%h", nm, idx, act, exp);
    end
  endtask

  function automatic void add(input logic rst, v, input logic [AW-1:0] a,
      input logic [63:0] dat, input logic last, ex, input logic [IAW-1:0] x,
      input logic done, dv, input logic [15:0] dt, dr, input logic fr, rr, ov);
    vec_t t;
    t.rst = rst; t.v = v; t.a = a; t.dat = dat; t.last = last; t.ex = ex;
    t.ia = x; t.done = done; t.e_dv = dv; t.e_dt = dt; t.e_dr = dr;
    t.e_fr = fr; t.e_rr = rr; t.e_ovf = ov;
    vecs.push_back(t);
  endfunction

  task automatic drive(input logic rst, v, input logic [AW-1:0] a,
      input logic [63:0] dat, input logic last, ex, input logic [IAW-1:0] x,
      input logic done);
    reset = rst; src_v = v; src_a = a; src_d = dat; src_last = last;
    exec = ex; ia = x; rd_done = done;
    @(posedge clk);
    #1;
  endtask

  task automatic check_all(input int idx, input logic dv, input logic [15:0] dt,
      input logic [15:0] dr, input logic fr, rr, ov);
    chk("d_v_trn", idx, {15'd0, dv_t}, {15'd0, dv});
    chk("d_v_rne", idx, {15'd0, dv_r}, {15'd0, dv});
    chk("d_trn", idx, d_t, dt);
    chk("d_rne", idx, d_r, dr);
    chk("fill_rdy", idx, {14'd0, fr_r, fr_t}, {14'd0, fr, fr});
    chk("rd_rdy", idx, {14'd0, rr_r, rr_t}, {14'd0, rr, rr});
    chk("ovf", idx, {14'd0, ovf_r, ovf_t}, {14'd0, ov, ov});
  endtask

  initial begin
    //   rst v  a       dat last ex ia       done  dv  d_trn    d_rne    fr rr ovf
    add(1, 0, 0,      0,  0, 0, 0,       0,    0, 16'h0000, 16'h0000, 1, 0, 0);
    add(0, 1, 0,      W0, 0, 0, 0,       0,    0, 16'h0000, 16'h0000, 1, 0, 0);
    add(0, 1, 1,      W1, 0, 0, 0,       0,    0, 16'h0000, 16'h0000, 1, 0, 0);
    add(0, 1, 2,      W2, 1, 0, 0,       0,    0, 16'h0000, 16'h0000, 1, 1, 0);
    add(0, 0, 0,      0,  0, 1, 0,       0,    1, 16'h3F80, 16'h3F80, 1, 1, 0);
    add(0, 0, 0,      0,  0, 1, 1,       0,    1, 16'h4049, 16'h4049, 1, 1, 0);
    add(0, 0, 0,      0,  0, 1, 2,       0,    1, 16'h3F80, 16'h3F80, 1, 1, 0);
    add(0, 0, 0,      0,  0, 1, 3,       0,    1, 16'h3F81, 16'h3F82, 1, 1, 0);
    add(0, 0, 0,      0,  0, 1, 4,       0,    1, 16'h3F80, 16'h3F81, 1, 1, 0);
    add(0, 0, 0,      0,  0, 1, 5,       0,    1, 16'h7F80, 16'h7FC0, 1, 1, 0);
    add(0, 0, 0,      0,  0, 0, 0,       0,    0, 16'h7F80, 16'h7FC0, 1, 1, 0);
    // fill set 1 while reading set 0
    add(0, 1, 0,      W3, 0, 1, 1,       0,    1, 16'h4049, 16'h4049, 1, 1, 0);
    add(0, 1, 1,      W4, 1, 1, 0,       0,    1, 16'h3F80, 16'h3F80, 0, 1, 0);
    add(0, 0, 0,      0,  0, 0, 0,       1,    0, 16'h3F80, 16'h3F80, 1, 1, 0);
    add(0, 0, 0,      0,  0, 1, 0,       0,    1, 16'hC000, 16'hC000, 1, 1, 0);
    add(0, 0, 0,      0,  0, 1, 3,       0,    1, 16'h3F00, 16'h3F00, 1, 1, 0);
    // both FULL, dropped write
    add(0, 1, 0,      W5, 1, 0, 0,       0,    0, 16'h3F00, 16'h3F00, 0, 1, 0);
    add(0, 1, 0,      WF, 0, 0, 0,       0,    0, 16'h3F00, 16'h3F00, 0, 1, 1);
    add(0, 0, 0,      0,  0, 1, 0,       0,    1, 16'hC000, 16'hC000, 0, 1, 1);
    add(0, 0, 0,      0,  0, 1, 1,       0,    1, 16'h4000, 16'h4000, 0, 1, 1);
    add(1, 0, 0,      0,  0, 0, 0,       0,    0, 16'h0000, 16'h0000, 1, 0, 0);
    // exec while not ready, then simultaneous close/release
    add(0, 0, 0,      0,  0, 1, 0,       0,    0, 16'h0000, 16'h0000, 1, 0, 1);
    add(0, 1, 0,      W0, 1, 0, 0,       0,    0, 16'h0000, 16'h0000, 1, 1, 1);
    add(0, 0, 0,      0,  0, 1, 1,       0,    1, 16'h4049, 16'h4049, 1, 1, 1);
    add(0, 0, 0,      0,  0, 0, 0,       1,    0, 16'h4049, 16'h4049, 1, 0, 1);
    add(0, 0, 0,      0,  0, 1, 0,       0,    0, 16'h4049, 16'h4049, 1, 0, 1);
    add(0, 1, 0,      W3, 1, 0, 0,       0,    0, 16'h4049, 16'h4049, 1, 1, 1);
    add(0, 1, 0,      W1, 1, 0, 0,       0,    0, 16'h4049, 16'h4049, 0, 1, 1);
    add(0, 0, 0,      0,  0, 1, 1,       1,    1, 16'h4000, 16'h4000, 1, 1, 1);
    add(0, 1, 0,      W4, 1, 0, 0,       1,    0, 16'h4000, 16'h4000, 1, 1, 1);
    add(0, 0, 0,      0,  0, 1, 0,       0,    1, 16'h4080, 16'h4080, 1, 1, 1);
    // bank boundary
    add(0, 1, 10'h1FF, W5, 0, 0, 0,      0,    0, 16'h4080, 16'h4080, 1, 1, 1);
    add(0, 1, 10'h200, W6, 1, 0, 0,      0,    0, 16'h4080, 16'h4080, 0, 1, 1);
    add(0, 0, 0,      0,  0, 0, 0,       1,    0, 16'h4080, 16'h4080, 1, 1, 1);
    add(0, 0, 0,      0,  0, 1, 11'h3FE, 0,    1, 16'h4120, 16'h4120, 1, 1, 1);
    add(0, 0, 0,      0,  0, 1, 11'h3FF, 0,    1, 16'h4100, 16'h4100, 1, 1, 1);
    add(0, 0, 0,      0,  0, 1, 11'h400, 0,    1, 16'h4160, 16'h4160, 1, 1, 1);
    add(0, 0, 0,      0,  0, 1, 11'h401, 0,    1, 16'h4140, 16'h4140, 1, 1, 1);
    add(0, 0, 0,      0,  0, 1, 0,       0,    1, 16'h3F80, 16'h3F80, 1, 1, 1);

    reset = 1'b1; src_v = 1'b0; src_a = '0; src_d = '0; src_last = 1'b0;
    exec = 1'b0; ia = '0; rd_done = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].rst, vecs[i].v, vecs[i].a, vecs[i].dat, vecs[i].last,
            vecs[i].ex, vecs[i].ia, vecs[i].done);
      check_all(i, vecs[i].e_dv, vecs[i].e_dt, vecs[i].e_dr,
                vecs[i].e_fr, vecs[i].e_rr, vecs[i].e_ovf);
    end

    // reset in the middle of a fill abandons the partial set
    drive(1, 0, 0, 0, 0, 0, 0, 0);
    drive(0, 1, 0, W6, 0, 0, 0, 0);
    drive(1, 1, 1, W6, 1, 0, 0, 0);
    check_all(100, 0, 16'h0000, 16'h0000, 1, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    check_all(101, 0, 16'h0000, 16'h0000, 1, 0, 0);
    drive(0, 1, 0, W0, 1, 0, 0, 0);
    check_all(102, 0, 16'h0000, 16'h0000, 1, 1, 0);
    drive(0, 0, 0, 0, 0, 1, 1, 0);
    check_all(103, 1, 16'h4049, 16'h4049, 1, 1, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
